crc8_serial_v: RTL and testbench

Bit-serial CRC-8 engine that consumes parallel words, one bit per clock, through an XOR2 feedback network. Sits directly downstream of the XOR2 gate stage in the datapath-components set: the XOR2 primitive forms its feedback and tap logic. Accepts a message as a stream of words over a valid/ready handshake and emits the 8-bit CRC after the word flagged last.

---
 rtl/crc8_serial_v_pkg.sv | 12 +
 rtl/crc8_serial_v_bit_step.sv | 39 +++
 rtl/crc8_serial_v.sv | 84 ++++++++
 tb/tb_crc8_serial_v.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/crc8_serial_v_pkg.sv
// Shared constants and FSM encoding for the bit-serial CRC-8 engine.
package crc8_serial_v_pkg;
    localparam int         CRC_W    = 8;
    localparam logic [7:0] DEF_POLY = 8'h07;
    localparam logic [7:0] DEF_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/crc8_serial_v_bit_step.sv
// Gate primitives and the single-bit CRC-8 update built from them.
module XOR2_v (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module AND2_v (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module crc8_bit_step_v
    import crc8_serial_v_pkg::*;
(
    input  logic [CRC_W-1:0] crc,
    input  logic             bit_in,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crc_nxt
);
    logic             fb;
    logic [CRC_W-1:0] shifted;
    logic [CRC_W-1:0] tap;

    XOR2_v u_fb (.a(crc[CRC_W-1]), .b(bit_in), .y(fb));

    assign shifted = {crc[CRC_W-2:0], 1'b0};

    // Each polynomial bit gates the feedback onto its own tap.
    for (genvar i = 0; i < CRC_W; i++) begin : g_tap
        AND2_v u_and (.a(fb), .b(poly[i]), .y(tap[i]));
        XOR2_v u_xor (.a(shifted[i]), .b(tap[i]), .y(crc_nxt[i]));
    end
endmodule

// File: rtl/crc8_serial_v.sv
// Bit-serial CRC-8: accepts DATA_W-bit words over valid/ready, shifts MSB first,
// and reports the CRC after the word flagged last.
module crc8_serial_v
    import crc8_serial_v_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter logic [7:0] POLY   = DEF_POLY,
    parameter logic [7:0] INIT   = DEF_INIT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_busy,
    output logic              o_crc_valid,
    output logic [7:0]        o_crc
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    logic [CRC_W-1:0]  crc;
    logic [CRC_W-1:0]  crc_nxt;
    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;
    logic              last_q;

    crc8_bit_step_v u_step (
        .crc     (crc),
        .bit_in  (sreg[DATA_W-1]),
        .poly    (POLY),
        .crc_nxt (crc_nxt)
    );

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            crc         <= INIT;
            sreg        <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            o_crc_valid <= 1'b0;
            o_crc       <= 8'h00;
        end else begin
            o_crc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sreg   <= i_data;
                        last_q <= i_last;
                        cnt    <= CNT_W'(DATA_W - 1);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc  <= crc_nxt;
                    sreg <= sreg << 1;
                    if (cnt == '0) begin
                        // Result is loaded on entry so it is already visible
                        // while the pulse is high in DONE.
                        if (last_q) begin
                            state       <= DONE;
                            o_crc       <= crc_nxt;
                            o_crc_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    crc   <= INIT;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc8_serial_v.sv
// Self-checking bench for crc8_serial_v against a polynomial long-division model.
module tb_crc8_serial_v;
    localparam int DATA_W = 8;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_last = 1'b0;
    logic              o_busy;
    logic              o_crc_valid;
    logic [7:0]        o_crc;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int last_ready_low = 0;

    crc8_serial_v #(.DATA_W(DATA_W), .POLY(8'h07), .INIT(8'h00)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_last      (i_last),
        .o_busy      (o_busy),
        .o_crc_valid (o_crc_valid),
        .o_crc       (o_crc)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_crc_valid) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Message * x^8 mod (x^8 + x^2 + x + 1), MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
        logic [8:0] r = 9'h000;
        logic       b;
        for (int i = 0; i < q.size() + 1; i++) begin
            for (int k = 7; k >= 0; k--) begin
                b = (i < q.size()) ? q[i][k] : 1'b0;
                r = {r[7:0], b};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        return r[7:0];
    endfunction

    // mode 0: valid low while waiting, 1: valid held high with the word, 2: random noise
    task automatic send(input logic [7:0] d, input logic last, input int mode);
        int lows = 0;
        bit ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (o_ready) begin
                i_valid = 1'b1; i_data = d; i_last = last;
                @(posedge i_clk);
                ok = 1;
                break;
            end
            lows++;
            case (mode)
                1: begin i_valid = 1'b1; i_data = d; i_last = last; end
                2: begin i_valid = 1'($urandom); i_data = 8'($urandom); i_last = 1'($urandom); end
                default: i_valid = 1'b0;
            endcase
        end
        if (!ok) chk("send_timeout", 0, 1);
        last_ready_low = lows;
    endtask

    task automatic run_msg(input string tag, input logic [7:0] q[$], input int mode,
                           input bit use_exp, input logic [7:0] exp);
        int p0 = pulses;
        int lat = 0;
        bit seen = 0;
        for (int i = 0; i < q.size(); i++) begin
            send(q[i], (i == q.size() - 1), mode);
            if (i > 0 && i < q.size() && mode != 2 && q.size() > 2 && i == q.size() - 1)
                chk({tag, "_ready_low"}, last_ready_low, DATA_W);
        end
        for (int n = 1; n < 50; n++) begin
            @(negedge i_clk);
            if (mode == 2) begin i_valid = 1'($urandom); i_data = 8'($urandom); end
            else i_valid = 1'b0;
            if (o_crc_valid) begin lat = n; seen = 1; break; end
        end
        i_valid = 1'b0;
        chk({tag, "_pulse_seen"}, seen, 1);
        chk({tag, "_latency"}, lat, DATA_W + 1);
        chk({tag, "_crc_model"}, o_crc, ref_crc(q));
        if (use_exp) chk({tag, "_crc_const"}, o_crc, exp);
        @(negedge i_clk);
        chk({tag, "_pulse_one_cycle"}, o_crc_valid, 0);
        chk({tag, "_pulse_count"}, pulses - p0, 1);
    endtask

    logic [7:0] msg[$];
    logic [7:0] ascii[$];

    initial begin
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_crc_valid, 0);
        chk("rst_crc", o_crc, 8'h00);
        i_rst = 1'b0;

        msg = '{8'h01}; run_msg("w01", msg, 0, 1, 8'h07);
        msg = '{8'h80}; run_msg("w80", msg, 0, 1, 8'h89);
        msg = '{8'h00}; run_msg("w00", msg, 0, 1, 8'h00);
        run_msg("ascii_hold", ascii, 1, 1, 8'hF4);
        msg = '{8'h01}; run_msg("b2b_a", msg, 1, 1, 8'h07);
        msg = '{8'h80}; run_msg("b2b_b", msg, 1, 1, 8'h89);

        // Abort a word mid-shift with a one-cycle reset.
        begin
            int p0;
            send(8'h31, 1'b1, 0);
            @(negedge i_clk); i_valid = 1'b0;
            chk("mid_busy", o_busy, 1);
            @(negedge i_clk); @(negedge i_clk);
            p0 = pulses;
            i_rst = 1'b1;
            @(negedge i_clk);
            i_rst = 1'b0;
            chk("abort_ready", o_ready, 1);
            chk("abort_busy", o_busy, 0);
            chk("abort_valid", o_crc_valid, 0);
            chk("abort_crc", o_crc, 8'h00);
            repeat (12) @(negedge i_clk);
            chk("abort_no_pulse", pulses - p0, 0);
        end
        msg = '{8'h01}; run_msg("after_rst", msg, 0, 1, 8'h07);

        run_msg("ascii_noise", ascii, 2, 1, 8'hF4);

        for (int m = 0; m < 6; m++) begin
            int len = $urandom_range(1, 6);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            run_msg($sformatf("rand%0d", m), msg, $urandom_range(0, 2), 0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
